// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - two-port round-robin arbiter and sequencer for the SRAM controller
module sram_req_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          rw0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          err0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          err1,
  output logic [DW-1:0] rdata1,
  output logic          mem_start,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          gnt
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t        state_q, state_d;
  logic [7:0]    wd_q, wd_d;
  logic          tout_q, tout_d;
  logic          gnt_q, gnt_d;
  logic          mem_start_q, mem_start_d;
  logic          mem_rw_q, mem_rw_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          busy_q, busy_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic          win;
  logic [7:0]    wd_inc;

  // Next-state, watchdog and registered-output computation for the sequencer
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    tout_d      = tout_q;
    gnt_d       = gnt_q;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;

    // With both ports requesting, the one not granted last time wins
    win    = (req0 && req1) ? ~gnt_q : req1;
    wd_inc = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;

    case (state_q)
      IDLE: begin
        if ((req0 || req1) && mem_ready) begin
          gnt_d       = win;
          mem_rw_d    = win ? rw1 : rw0;
          mem_addr_d  = win ? addr1 : addr0;
          mem_wdata_d = win ? wdata1 : wdata0;
          tout_d      = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = 8'd0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!mem_ready) begin
          wd_d    = 8'd0;
          state_d = WAIT_DONE;
        end else begin
          wd_d = wd_inc;
          if (wd_inc >= TIMEOUT_C) begin
            tout_d  = 1'b1;
            state_d = RESP;
          end
        end
      end
      WAIT_DONE: begin
        if (mem_ready) begin
          if (!mem_rw_q) begin
            if (gnt_q) rdata1_d = mem_rdata;
            else       rdata0_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          wd_d = wd_inc;
          if (wd_inc >= TIMEOUT_C) begin
            tout_d  = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        tout_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered
    if (state_d == RESP) begin
      ack0_d = ~gnt_q;
      ack1_d = gnt_q;
      err0_d = ~gnt_q & tout_d;
      err1_d = gnt_q & tout_d;
    end
    mem_start_d = (state_d == ISSUE);
    busy_d      = (state_d != IDLE);
  end

  // State and output registers; reset returns every output to its idle value at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wd_q        <= 8'd0;
      tout_q      <= 1'b0;
      gnt_q       <= 1'b1;
      mem_start_q <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      tout_q      <= tout_d;
      gnt_q       <= gnt_d;
      mem_start_q <= mem_start_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign mem_start = mem_start_q;
  assign mem_rw    = mem_rw_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign gnt       = gnt_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;

endmodule
